// File: rtl/lc3_wb_pkg.sv
// Shared types and constants for the LC-3 register write-back sequencer.
// The optional WB_SCOREBOARD_EN feature lives in reg_writeback.sv.
package lc3_wb_pkg;

    localparam int WB_DATA_W   = 16;
    localparam int WB_REG_AW   = 3;
    localparam int WB_NUM_REGS = 8;

    localparam logic [2:0] NZP_RESET = 3'b010;
    localparam int NZP_N = 2;
    localparam int NZP_Z = 1;
    localparam int NZP_P = 0;

    typedef struct packed {
        logic [WB_REG_AW-1:0] dr;
        logic [WB_DATA_W-1:0] data;
        logic                 setcc;
    } wb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE
    } wb_state_e;

    // Exactly one bit is set: negative wins, then zero, otherwise positive.
    function automatic logic [2:0] calcNzp(input logic [WB_DATA_W-1:0] value);
        logic [2:0] cc;
        cc = 3'b000;
        if (value[WB_DATA_W-1]) begin
            cc[NZP_N] = 1'b1;
        end else if (value == '0) begin
            cc[NZP_Z] = 1'b1;
        end else begin
            cc[NZP_P] = 1'b1;
        end
        return cc;
    endfunction

endpackage

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: DEPTH-entry circular buffer of write-back entries.
// Push and pop are gated internally by the pre-edge full/empty flags.
module wb_fifo
    import lc3_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      Clk,
    input  logic      Reset,
    input  logic      push_i,
    input  wb_entry_t entry_i,
    input  logic      pop_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pushOk;
    logic             popOk;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pushOk  = push_i && !full_o;
    assign popOk   = pop_i && !empty_o;
    assign head_o  = mem_q[rdPtr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (pushOk) begin
            wrPtr_d = wrPtr_q + PTR_W'(1);
        end
        if (popOk) begin
            rdPtr_d = rdPtr_q + PTR_W'(1);
        end
        case ({pushOk, popOk})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (pushOk) begin
            mem_q[wrPtr_q] <= entry_i;
        end
    end

endmodule

// File: rtl/reg_writeback.sv
// Write-back sequencer feeding the 8x16 regfile (DR, D_in, LD_REG) and the NZP codes.
// Define WB_SCOREBOARD_EN to build per-register pending-write counters for busy_mask.
module reg_writeback
    import lc3_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_AW-1:0] wb_dr,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              wb_setcc,
    output logic [REG_AW-1:0] DR,
    output logic [DATA_W-1:0] D_in,
    output logic              LD_REG,
    output logic [2:0]        nzp,
    output logic [7:0]        busy_mask
);

    wb_state_e         state_q, state_d;
    logic [REG_AW-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              setcc_q, setcc_d;
    logic              ldReg_q, ldReg_d;
    logic [2:0]        nzp_q, nzp_d;
    logic              fifoPop;
    logic              fifoFull;
    logic              fifoEmpty;
    logic              retire;
    wb_entry_t         pushEntry;
    wb_entry_t         headEntry;

    assign pushEntry = '{dr: wb_dr, data: wb_data, setcc: wb_setcc};
    assign wb_ready  = !fifoFull;

    wb_fifo #(
        .DEPTH (DEPTH)
    ) uFifo (
        .Clk     (Clk),
        .Reset   (Reset),
        .push_i  (wb_valid),
        .entry_i (pushEntry),
        .pop_i   (fifoPop),
        .head_o  (headEntry),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // SETUP always precedes STROBE so LD_REG gets a low cycle before every rising edge.
    always_comb begin
        state_d = state_q;
        dr_d    = dr_q;
        data_d  = data_q;
        setcc_d = setcc_q;
        ldReg_d = 1'b0;
        nzp_d   = nzp_q;
        fifoPop = 1'b0;
        retire  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    dr_d    = headEntry.dr;
                    data_d  = headEntry.data;
                    setcc_d = headEntry.setcc;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                ldReg_d = 1'b1;
                state_d = STROBE;
            end
            STROBE: begin
                retire = 1'b1;
                if (setcc_q) begin
                    nzp_d = calcNzp(data_q);
                end
                if (!fifoEmpty) begin
                    fifoPop = 1'b1;
                    dr_d    = headEntry.dr;
                    data_d  = headEntry.data;
                    setcc_d = headEntry.setcc;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            dr_q    <= '0;
            data_q  <= '0;
            setcc_q <= 1'b0;
            ldReg_q <= 1'b0;
            nzp_q   <= NZP_RESET;
        end else begin
            state_q <= state_d;
            dr_q    <= dr_d;
            data_q  <= data_d;
            setcc_q <= setcc_d;
            ldReg_q <= ldReg_d;
            nzp_q   <= nzp_d;
        end
    end

    assign DR     = dr_q;
    assign D_in   = data_q;
    assign LD_REG = ldReg_q;
    assign nzp    = nzp_q;

`ifdef WB_SCOREBOARD_EN
    // Sized for DEPTH queued entries plus the one being strobed.
    localparam int SB_W = $clog2(DEPTH + 1) + 1;

    logic [SB_W-1:0] pend_q [WB_NUM_REGS];
    logic            accept;

    assign accept = wb_valid && wb_ready;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            for (int r = 0; r < WB_NUM_REGS; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            for (int r = 0; r < WB_NUM_REGS; r++) begin
                if (accept && (wb_dr == REG_AW'(r)) && !(retire && (dr_q == REG_AW'(r)))) begin
                    pend_q[r] <= pend_q[r] + SB_W'(1);
                end else if (retire && (dr_q == REG_AW'(r)) && !(accept && (wb_dr == REG_AW'(r)))) begin
                    pend_q[r] <= pend_q[r] - SB_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy_mask = '0;
        for (int r = 0; r < WB_NUM_REGS; r++) begin
            busy_mask[r] = (pend_q[r] != '0);
        end
    end
`else
    assign busy_mask = 8'b0;
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed self-checking bench for reg_writeback with a behavioural regfile model.
// Expects busy_mask activity only when WB_SCOREBOARD_EN is defined.
module tb_reg_writeback;

    logic        Clk;
    logic        Reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [2:0]  wb_dr;
    logic [15:0] wb_data;
    logic        wb_setcc;
    logic [2:0]  DR;
    logic [15:0] D_in;
    logic        LD_REG;
    logic [2:0]  nzp;
    logic [7:0]  busy_mask;

    int testCount = 0;
    int failCount = 0;
    int cycle = 0;
    int glitchCount = 0;
    int unstableCount = 0;
    logic fullSeen;

    logic [2:0]  qDr[$];
    logic [15:0] qData[$];
    logic [2:0]  qNzp[$];
    int          qCycle[$];
    logic        ldPrev;
    logic [2:0]  prevDr;
    logic [15:0] prevData;

    logic [15:0] rfModel [8];
    logic [2:0]  sr1Addr, sr2Addr;
    logic [15:0] sr1Data, sr2Data;
    logic [7:0]  busyExp;

    reg_writeback #(.DEPTH(4), .DATA_W(16), .REG_AW(3)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .wb_valid  (wb_valid),
        .wb_ready  (wb_ready),
        .wb_dr     (wb_dr),
        .wb_data   (wb_data),
        .wb_setcc  (wb_setcc),
        .DR        (DR),
        .D_in      (D_in),
        .LD_REG    (LD_REG),
        .nzp       (nzp),
        .busy_mask (busy_mask)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    always @(posedge Clk) cycle++;

    // Regfile latches on the rising edge of LD_REG; two combinational read ports.
    initial for (int i = 0; i < 8; i++) rfModel[i] = '0;
    always @(posedge LD_REG) rfModel[DR] = D_in;
    assign sr1Data = rfModel[sr1Addr];
    assign sr2Data = rfModel[sr2Addr];

    // Logs every strobe, the nzp after each strobe exit and any strobe-shape violations.
    always @(negedge Clk) begin
        if (Reset) begin
            ldPrev = 1'b0;
        end else begin
            if (LD_REG && ldPrev) glitchCount++;
            if (LD_REG && ((DR !== prevDr) || (D_in !== prevData))) unstableCount++;
            if (LD_REG) begin
                qDr.push_back(DR);
                qData.push_back(D_in);
                qCycle.push_back(cycle);
            end
            if (ldPrev && !LD_REG) qNzp.push_back(nzp);
            ldPrev   = LD_REG;
            prevDr   = DR;
            prevData = D_in;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Holds wb_valid until the handshake edge; returns 1ns after it with wb_valid low.
    task automatic applyStimulus(input logic [2:0] dr, input logic [15:0] data, input logic setcc);
        int n;
        wb_valid = 1'b1;
        wb_dr    = dr;
        wb_data  = data;
        wb_setcc = setcc;
        n = 0;
        while (!wb_ready && n < 50) begin
            fullSeen = 1'b1;
            tick();
            n++;
        end
        checkOutput("push_ready", {31'b0, wb_ready}, 32'd1);
        tick();
        wb_valid = 1'b0;
    endtask

    task automatic waitExits(input string tag, input int n);
        int k;
        k = 0;
        while (qNzp.size() < n && k < 200) begin
            tick();
            k++;
        end
        checkOutput(tag, qNzp.size(), n);
    endtask

    task automatic clearLogs();
        qDr.delete();
        qData.delete();
        qNzp.delete();
        qCycle.delete();
        glitchCount   = 0;
        unstableCount = 0;
        fullSeen      = 1'b0;
    endtask

    initial begin
        Reset    = 1'b1;
        wb_valid = 1'b0;
        wb_dr    = '0;
        wb_data  = '0;
        wb_setcc = 1'b0;
        sr1Addr  = '0;
        sr2Addr  = '0;
        fullSeen = 1'b0;
        ldPrev   = 1'b0;
        prevDr   = '0;
        prevData = '0;
`ifdef WB_SCOREBOARD_EN
        busyExp = 8'h20;
`else
        busyExp = 8'h00;
`endif
        repeat (2) tick();
        checkOutput("rst_ready", {31'b0, wb_ready}, 32'd1);
        checkOutput("rst_ld", {31'b0, LD_REG}, 32'd0);
        checkOutput("rst_dr", {29'b0, DR}, 32'd0);
        checkOutput("rst_din", {16'b0, D_in}, 32'd0);
        checkOutput("rst_nzp", {29'b0, nzp}, 32'b010);
        checkOutput("rst_busy", {24'b0, busy_mask}, 32'd0);
        Reset = 1'b0;
        repeat (2) tick();

        // Single write latency and positive nzp.
        clearLogs();
        applyStimulus(3'd3, 16'h1234, 1'b1);
        checkOutput("t1_ld_e0", {31'b0, LD_REG}, 32'd0);
        tick();
        checkOutput("t1_dr_e1", {29'b0, DR}, 32'd3);
        checkOutput("t1_din_e1", {16'b0, D_in}, 32'h1234);
        checkOutput("t1_ld_e1", {31'b0, LD_REG}, 32'd0);
        tick();
        checkOutput("t1_ld_e2", {31'b0, LD_REG}, 32'd1);
        checkOutput("t1_nzp_e2", {29'b0, nzp}, 32'b010);
        tick();
        checkOutput("t1_ld_e3", {31'b0, LD_REG}, 32'd0);
        checkOutput("t1_nzp_e3", {29'b0, nzp}, 32'b001);
        repeat (3) tick();

        // nzp sequence: negative, zero, then a non-setcc write leaves it alone.
        clearLogs();
        applyStimulus(3'd1, 16'h8000, 1'b1);
        applyStimulus(3'd2, 16'h0000, 1'b1);
        applyStimulus(3'd4, 16'h0005, 1'b0);
        waitExits("t2_exits", 3);
        checkOutput("t2_nzp0", {29'b0, qNzp.size() > 0 ? qNzp[0] : 3'bxxx}, 32'b100);
        checkOutput("t2_nzp1", {29'b0, qNzp.size() > 1 ? qNzp[1] : 3'bxxx}, 32'b010);
        checkOutput("t2_nzp2", {29'b0, qNzp.size() > 2 ? qNzp[2] : 3'bxxx}, 32'b010);
        checkOutput("t2_data2", {16'b0, qData.size() > 2 ? qData[2] : 16'hxxxx}, 32'h0005);
        checkOutput("t2_gap", glitchCount, 0);
        checkOutput("t2_stable", unstableCount, 0);
        repeat (3) tick();

        // Back-to-back pushes outrun the 2-cycle drain and fill the FIFO.
        clearLogs();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 16'h0100 + 16'(i), 1'b0);
            wb_valid = 1'b1;
        end
        wb_valid = 1'b0;
        checkOutput("t3_full_seen", {31'b0, fullSeen}, 32'd1);
        applyStimulus(3'd7, 16'hF007, 1'b1);
        waitExits("t3_exits", 9);
        checkOutput("t3_count", qData.size(), 9);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("t3_dr%0d", i), {29'b0, qDr.size() > i ? qDr[i] : 3'bxxx}, 32'(i));
            checkOutput($sformatf("t3_data%0d", i), {16'b0, qData.size() > i ? qData[i] : 16'hxxxx}, 32'h0100 + 32'(i));
        end
        for (int i = 1; i < 8; i++) begin
            checkOutput($sformatf("t3_spacing%0d", i),
                        qCycle.size() > i ? qCycle[i] - qCycle[i-1] : -1, 2);
        end
        checkOutput("t3_nzp_last", {29'b0, nzp}, 32'b100);
        checkOutput("t3_gap", glitchCount, 0);
        checkOutput("t3_stable", unstableCount, 0);
        repeat (3) tick();

        // Reset lands mid-strobe with two entries still queued.
        clearLogs();
        applyStimulus(3'd1, 16'h0001, 1'b1);
        applyStimulus(3'd2, 16'h0002, 1'b1);
        applyStimulus(3'd3, 16'h0003, 1'b1);
        begin
            int k;
            k = 0;
            while (!LD_REG && k < 20) begin
                tick();
                k++;
            end
        end
        checkOutput("t4_in_strobe", {31'b0, LD_REG}, 32'd1);
        #2;
        Reset = 1'b1;
        #1;
        checkOutput("t4_ld_async", {31'b0, LD_REG}, 32'd0);
        checkOutput("t4_nzp", {29'b0, nzp}, 32'b010);
        checkOutput("t4_ready", {31'b0, wb_ready}, 32'd1);
        tick();
        Reset = 1'b0;
        begin
            int strobesBefore;
            strobesBefore = qDr.size();
            repeat (10) tick();
            checkOutput("t4_no_strobes", qDr.size(), strobesBefore);
        end
        checkOutput("t4_nzp_after", {29'b0, nzp}, 32'b010);

        // Two pending writes to R5 keep it busy until the second retires.
        clearLogs();
        applyStimulus(3'd5, 16'h0055, 1'b0);
        checkOutput("t5_busy_e0", {24'b0, busy_mask}, {24'b0, busyExp});
        applyStimulus(3'd5, 16'h0056, 1'b0);
        checkOutput("t5_busy_e1", {24'b0, busy_mask}, {24'b0, busyExp});
        for (int e = 2; e <= 4; e++) begin
            tick();
            checkOutput($sformatf("t5_busy_e%0d", e), {24'b0, busy_mask}, {24'b0, busyExp});
        end
        tick();
        checkOutput("t5_busy_e5", {24'b0, busy_mask}, 32'd0);
        repeat (3) tick();

        // Regfile co-simulation across all eight registers.
        clearLogs();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(3'(i), 16'(i) * 16'h1111, 1'b0);
        end
        waitExits("t6_exits", 8);
        tick();
        for (int i = 0; i < 8; i++) begin
            sr1Addr = 3'(i);
            sr2Addr = 3'(7 - i);
            #1;
            checkOutput($sformatf("t6_sr1_r%0d", i), {16'b0, sr1Data}, 32'(i) * 32'h1111);
            checkOutput($sformatf("t6_sr2_r%0d", 7 - i), {16'b0, sr2Data}, 32'(7 - i) * 32'h1111);
        end
        checkOutput("t6_gap", glitchCount, 0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
